// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit: word-wide req/ack memory port with byte enables,
// sub-word lane steering and extension, stall generation and a BUSY timeout.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        re_in,
  input  logic        we_in,
  input  logic [1:0]  size_in,
  input  logic        zext_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        stall_out,
  output logic [31:0] rdata_out,
  output logic        misaligned_out,
  output logic        bus_err_out,
  output logic        mem_req_out,
  output logic        mem_we_out,
  output logic [31:0] mem_addr_out,
  output logic [3:0]  mem_be_out,
  output logic [31:0] mem_wdata_out,
  input  logic [31:0] mem_rdata_in,
  input  logic        mem_ack_in
);

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic        we_q, zext_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic [15:0] cnt_q, cnt_d;
  logic        mis_q, err_q;

  logic        req_any, is_byte, is_half, misaligned, start, timeout;
  logic [3:0]  be_new;
  logic [31:0] wdata_new, load_ext;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign req_any    = we_in | re_in;
  assign is_byte    = (size_in == 2'b00);
  assign is_half    = (size_in == 2'b01);
  assign misaligned = (is_half & addr_in[0]) | (~is_byte & ~is_half & (addr_in[1:0] != 2'b00));
  assign start      = (state_q == StIdle) & req_any & ~misaligned;
  assign timeout    = (state_q == StBusy) & ~mem_ack_in & (cnt_q == TimeoutLast);

  always_comb begin
    be_new    = 4'b1111;
    wdata_new = wdata_in;
    if (is_byte) begin
      be_new    = 4'b0001 << addr_in[1:0];
      wdata_new = {4{wdata_in[7:0]}};
    end else if (is_half) begin
      be_new    = addr_in[1] ? 4'b1100 : 4'b0011;
      wdata_new = {2{wdata_in[15:0]}};
    end
  end

  // Lane extraction uses the latched access, never the live decoder inputs.
  always_comb begin
    lane_b   = mem_rdata_in[8*addr_q[1:0] +: 8];
    lane_h   = addr_q[1] ? mem_rdata_in[31:16] : mem_rdata_in[15:0];
    load_ext = mem_rdata_in;
    if (size_q == 2'b00) begin
      load_ext = {{24{~zext_q & lane_b[7]}}, lane_b};
    end else if (size_q == 2'b01) begin
      load_ext = {{16{~zext_q & lane_h[15]}}, lane_h};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StBusy;
          cnt_d   = 16'd0;
        end
      end
      StBusy: begin
        if (mem_ack_in || timeout) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= StIdle;
      cnt_q   <= 16'd0;
      we_q    <= 1'b0;
      zext_q  <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mis_q   <= (state_q == StIdle) & req_any & misaligned;
      err_q   <= timeout;
      if (start) begin
        we_q    <= we_in;
        zext_q  <= zext_in;
        size_q  <= size_in;
        addr_q  <= addr_in;
        be_q    <= be_new;
        wdata_q <= wdata_new;
      end
      if ((state_q == StBusy) && mem_ack_in && !we_q) begin
        rdata_q <= load_ext;
      end
    end
  end

  assign stall_out      = start | (state_q == StBusy);
  assign rdata_out      = rdata_q;
  assign misaligned_out = mis_q;
  assign bus_err_out    = err_q;
  assign mem_req_out    = (state_q == StBusy);
  assign mem_we_out     = we_q;
  assign mem_addr_out   = {addr_q[31:2], 2'b00};
  assign mem_be_out     = be_q;
  assign mem_wdata_out  = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver pushes expectations, a monitor
// pops and checks memory requests, completions, pulses and load-result hold.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        re_in = 1'b0, we_in = 1'b0, zext_in = 1'b0;
  logic [1:0]  size_in = 2'b00;
  logic [31:0] addr_in = 32'd0, wdata_in = 32'd0;
  logic        stall_out, misaligned_out, bus_err_out;
  logic [31:0] rdata_out;
  logic        mem_req_out, mem_we_out;
  logic [31:0] mem_addr_out, mem_wdata_out;
  logic [3:0]  mem_be_out;
  logic [31:0] mem_rdata_in = 32'd0;
  logic        mem_ack_in = 1'b0;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .re_in(re_in), .we_in(we_in),
    .size_in(size_in), .zext_in(zext_in), .addr_in(addr_in), .wdata_in(wdata_in),
    .stall_out(stall_out), .rdata_out(rdata_out), .misaligned_out(misaligned_out),
    .bus_err_out(bus_err_out), .mem_req_out(mem_req_out), .mem_we_out(mem_we_out),
    .mem_addr_out(mem_addr_out), .mem_be_out(mem_be_out), .mem_wdata_out(mem_wdata_out),
    .mem_rdata_in(mem_rdata_in), .mem_ack_in(mem_ack_in)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } done_t;

  req_t        exp_req_q[$];
  done_t       exp_done_q[$];
  int          exp_mis = 0;
  int          n_cmp = 0, n_fail = 0;
  int          ack_delay = -1;
  logic [31:0] rd_word = 32'd0;
  logic        stray_ack = 1'b0;
  logic [31:0] model_rdata = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_load(input int nb, input logic zext,
                                           input logic [1:0] lo, input logic [31:0] word);
    logic [31:0] v, mask;
    if (nb == 4) return word;
    v    = word >> (8 * lo);
    mask = (32'd1 << (8 * nb)) - 32'd1;
    v    = v & mask;
    if (!zext && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  // Memory responder: acks `ack_delay` cycles into the request (-1: never).
  initial begin
    int rcnt = 0;
    forever begin
      @(negedge clk_in);
      if (stray_ack) begin
        mem_ack_in   = 1'b1;
        mem_rdata_in = 32'hBAD0BAD0;
      end else if (mem_req_out) begin
        mem_ack_in   = (rcnt == ack_delay);
        mem_rdata_in = mem_ack_in ? rd_word : $urandom();
        rcnt++;
      end else begin
        mem_ack_in = 1'b0;
        rcnt       = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an event.
  initial begin
    logic        prev_req = 1'b0;
    logic [31:0] cur_rdata = 32'd0;
    req_t        cur;
    done_t       d;
    logic        is_done;
    cur = '0;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        prev_req  = 1'b0;
        cur_rdata = 32'd0;
      end else begin
        if (mem_req_out && !prev_req) begin
          if (exp_req_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
          else cur = exp_req_q.pop_front();
        end
        if (mem_req_out) begin
          chk("mem_we", {31'd0, mem_we_out}, {31'd0, cur.we});
          chk("mem_addr", mem_addr_out, cur.addr);
          chk("mem_be", {28'd0, mem_be_out}, {28'd0, cur.be});
          if (cur.we) chk("mem_wdata", mem_wdata_out, cur.wdata);
        end
        is_done = prev_req && !mem_req_out;
        if (is_done) begin
          if (exp_done_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            d = exp_done_q.pop_front();
            chk("done_rdata", rdata_out, d.rdata);
            chk("done_bus_err", {31'd0, bus_err_out}, {31'd0, d.err});
            cur_rdata = d.rdata;
          end
        end else begin
          chk("rdata_hold", rdata_out, cur_rdata);
          if (bus_err_out) chk("bus_err_spurious", 32'd1, 32'd0);
        end
        if (misaligned_out) begin
          chk("misaligned_expected", {31'd0, exp_mis > 0}, 32'd1);
          chk("mis_err_exclusive", {31'd0, bus_err_out}, 32'd0);
          if (exp_mis > 0) exp_mis--;
        end
        prev_req = mem_req_out;
      end
    end
  end

  task automatic access(input logic we, input logic re, input logic [1:0] size,
                        input logic zext, input logic [31:0] addr, input logic [31:0] wdata,
                        input int delay, input logic [31:0] word);
    int   nb, cycles, exp_stall;
    logic err;
    req_t r;
    nb  = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    @(posedge clk_in);
    #1;
    if ((addr % nb) != 0) begin
      exp_mis++;
      we_in = we; re_in = re; size_in = size; zext_in = zext;
      addr_in = addr; wdata_in = wdata;
      @(negedge clk_in);
      chk("mis_stall", {31'd0, stall_out}, 32'd0);
      @(posedge clk_in);
      #1;
      we_in = 1'b0; re_in = 1'b0;
      return;
    end
    err       = (delay < 0) || (delay >= TO);
    exp_stall = err ? TO + 1 : delay + 2;
    r.we      = we;
    r.addr    = addr & 32'hFFFF_FFFC;
    r.be      = 4'(((1 << nb) - 1) << (addr % 4));
    r.wdata   = (nb == 1) ? {4{wdata[7:0]}} : (nb == 2) ? {2{wdata[15:0]}} : wdata;
    if (!we && !err) model_rdata = ref_load(nb, zext, addr[1:0], word);
    exp_req_q.push_back(r);
    exp_done_q.push_back('{err: err, rdata: model_rdata});
    ack_delay = delay; rd_word = word;
    we_in = we; re_in = re; size_in = size; zext_in = zext;
    addr_in = addr; wdata_in = wdata;
    cycles = 0;
    @(negedge clk_in);
    while (stall_out && cycles < 100) begin
      cycles++;
      @(negedge clk_in);
    end
    chk("stall_cycles", cycles, exp_stall);
    @(posedge clk_in);
    #1;
    we_in = 1'b0; re_in = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          nb;
    logic [1:0]  sz;
    logic        w;
    #3;
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    chk("rst_req", {31'd0, mem_req_out}, 32'd0);
    chk("rst_rdata", rdata_out, 32'd0);
    chk("rst_outs", {mem_addr_out | mem_wdata_out}, 32'd0);
    chk("rst_misc", {26'd0, mem_we_out, mem_be_out, misaligned_out}, 32'd0);
    chk("rst_buserr", {31'd0, bus_err_out}, 32'd0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;

    access(1'b0, 1'b1, 2'b11, 1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF);
    access(1'b0, 1'b1, 2'b00, 1'b0, 32'h203, 32'h0, 0, 32'h80FF_FF7F);
    access(1'b0, 1'b1, 2'b00, 1'b1, 32'h203, 32'h0, 2, 32'h80FF_FF7F);
    access(1'b1, 1'b0, 2'b01, 1'b0, 32'h42, 32'h1234ABCD, 1, 32'h0);
    access(1'b0, 1'b1, 2'b11, 1'b0, 32'h102, 32'h0, 0, 32'h0);
    access(1'b1, 1'b0, 2'b01, 1'b0, 32'h101, 32'h5555, 0, 32'h0);
    access(1'b0, 1'b1, 2'b01, 1'b0, 32'h302, 32'h0, -1, 32'h1111_2222);

    // Reset while BUSY, then a stray ack that must not disturb anything.
    @(posedge clk_in);
    #1;
    ack_delay = -1;
    exp_req_q.push_back('{we: 1'b0, addr: 32'h400, be: 4'hF, wdata: 32'h0});
    re_in = 1'b1; size_in = 2'b11; addr_in = 32'h400;
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1; re_in = 1'b0;
    model_rdata = 32'd0;
    #1;
    chk("rst_busy_req", {31'd0, mem_req_out}, 32'd0);
    chk("rst_busy_stall", {31'd0, stall_out}, 32'd0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0; stray_ack = 1'b1;
    @(posedge clk_in);
    #1;
    stray_ack = 1'b0;
    chk("stray_ack_rdata", rdata_out, 32'd0);
    access(1'b0, 1'b1, 2'b11, 1'b0, 32'h404, 32'h0, 1, 32'hCAFE_F00D);

    for (int i = 0; i < 60; i++) begin
      sz = 2'($urandom_range(3));
      nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      a  = $urandom();
      if ($urandom_range(3) != 0) a = a & ~(32'(nb) - 32'd1);
      w  = 1'($urandom_range(1));
      access(w, w ? 1'($urandom_range(1)) : 1'b1, sz, 1'($urandom_range(1)), a,
             $urandom(), int'($urandom_range(5)) - 1, $urandom());
    end

    repeat (5) @(posedge clk_in);
    chk("req_q_empty", 32'(exp_req_q.size()), 32'd0);
    chk("done_q_empty", 32'(exp_done_q.size()), 32'd0);
    chk("mis_all_seen", 32'(exp_mis), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle load/store unit between the control/ALU stage and the data memory. Consumes the decoder's data-memory controls (read enable, write enable, size, extension select) plus the ALU address and store data. Drives a word-wide request/acknowledge memory port with byte enables and returns an aligned, extended load result. Holds the processor (stall) until the access completes, times out or is rejected as misaligned.

## Interface
- TIMEOUT, default 255: cycles in BUSY without `mem_ack_in` before abort; legal range 1..65535.
- clk_in  input  1  system clock; all state updates on the rising edge.
- rst_in  input  1  reset, asynchronous, active-high.
- re_in  input  1  load request, from control `data_mem_re_out`.
- we_in  input  1  store request, from control `data_mem_we_out`; has priority over `re_in` if both are high.
- size_in  input  2  access size: 00 byte, 01 halfword, 11 word; 10 is treated as word.
- zext_in  input  1  from control `signed_out`:
  - 1 = zero-extend (lbu/lhu).
  - 0 = sign-extend.
  - Ignored for stores and for word loads.
- addr_in  input  32  byte address from the ALU.
- wdata_in  input  32  store data; the low byte or halfword is used for sub-word stores.
- stall_out  output  1  high while an access is pending; gates the PC enable.
- rdata_out  output  32  extended load result, held until the next completed load.
- misaligned_out  output  1  one-cycle pulse when an access is rejected.
- bus_err_out  output  1  one-cycle pulse on timeout.
- mem_req_out  output  1  memory request, held until acknowledged.
- mem_we_out  output  1  1 = write.
- mem_addr_out  output  32  word address: {addr[31:2], 2'b00}.
- mem_be_out  output  4  byte enables; bit i selects bits 8i+7:8i.
- mem_wdata_out  output  32  lane-replicated store data.
- mem_rdata_in  input  32  read data; valid in the cycle `mem_ack_in` is high.
- mem_ack_in  input  1  single-cycle acknowledge.

## Operation
- Little-endian lanes: byte lane = addr[1:0]; halfword lane = addr[1] (0 → bits 15:0, 1 → bits 31:16).
- Byte enables:
  - Byte access: 4'b0001 << addr[1:0].
  - Halfword access: 0011 or 1100.
  - Word access: 1111.
  - The same enables are driven for loads.
- Store data: byte replicated ×4; halfword replicated ×2; word passed through.
- Load extraction:
  - Select the lane from the captured `mem_rdata_in`.
  - Extend to 32 bits per the latched `zext`.
- Misaligned access: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - No memory request is issued.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If `we_in|re_in` is high and the access is aligned: `stall_out`=1 combinationally in the same cycle; latch we, size, zext, addr and wdata; go to BUSY.
  - If the access is misaligned: `misaligned_out` is registered high for the next cycle, `stall_out` stays 0, remain in IDLE, `rdata_out` is unchanged.
- BUSY:
  - `mem_req_out`=1, `stall_out`=1; memory outputs are driven from latched registers and are stable.
  - On `mem_ack_in`: if the access is a load, load `rdata_out` with the extended data; go to DONE.
  - Timeout counter reset to 0 on entry, increments each cycle without ack. When the count reaches TIMEOUT-1 with no ack: go to DONE, pulse `bus_err_out` on the next cycle, leave `rdata_out` unchanged.
  - Ack and timeout in the same cycle: ack wins.
- DONE:
  - `stall_out`=0 for exactly one cycle; the PC advances at the end of this cycle.
  - New requests are ignored in this cycle; this prevents re-issue of the instruction still presented.
  - Go to IDLE.
- `mem_ack_in` is ignored outside BUSY.

## Timing
- Reset values: state IDLE, `stall_out` 0, `rdata_out` 0, `misaligned_out` 0, `bus_err_out` 0, `mem_req_out` 0, `mem_we_out` 0, `mem_addr_out` 0, `mem_be_out` 0, `mem_wdata_out` 0, timeout counter 0.
- Request in cycle T with ack arriving k cycles after BUSY entry (k ≥ 0):
  - BUSY occupies cycles T+1 .. T+1+k.
  - DONE is cycle T+2+k.
  - `rdata_out` is valid from cycle T+2+k.
  - Minimum stall: 2 cycles (T, T+1) before the DONE cycle.
- `misaligned_out` and `bus_err_out` are registered and never high in the same cycle.
- Reset asserted mid-BUSY: `mem_req_out` drops asynchronously and the FSM returns to IDLE; the memory must discard an acknowledge after reset.

## Test plan
- Word load: re=1, size=11, addr=0x100; ack after 3 cycles with rdata=0xDEADBEEF.
  - mem_addr=0x100, be=1111, stall for cycles T..T+4.
  - rdata_out=0xDEADBEEF in DONE.
- Signed and unsigned byte loads: addr=0x203, mem_rdata=0x80FF_FF7F.
  - zext=0 → rdata_out=0xFFFFFF80.
  - zext=1 → rdata_out=0x00000080.
  - be=1000 for both.
- Halfword store: we=1, size=01, addr=0x42, wdata=0x1234ABCD.
  - mem_we=1, mem_addr=0x40, be=1100, mem_wdata=0xABCDABCD, rdata_out unchanged.
- Misaligned accesses: word load at 0x102 and halfword store at 0x101.
  - No mem_req; misaligned_out is one pulse each; stall_out stays 0.
- Timeout: TIMEOUT=4, no ack.
  - Four BUSY cycles, then DONE; bus_err_out pulses once; rdata_out keeps its prior value.
- Reset in BUSY: assert rst_in mid-request.
  - mem_req_out=0 and stall_out=0 immediately; a subsequent ack is ignored; the next load completes normally.
